// File: rtl/wavegen_sched_if.sv
// ---------------------------------------------------------------------------
// wavegen_sched_if
//   Config handshake between the CPU/config bus and wavegen_sched.
//   A transfer happens on any clk edge where cfg_valid & cfg_ready.
//
//   cfg_valid  master -> slave   config request
//   cfg_ready  slave  -> master  config accept
//   cfg_ch     master -> slave   target channel
//   cfg_inc    master -> slave   phase increment per frame (A bits)
//   cfg_en     master -> slave   channel enable
// ---------------------------------------------------------------------------
interface wavegen_sched_if #(
   parameter int NCH = 4,
   parameter int A   = 13
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic [A-1:0]  cfg_inc;
   logic          cfg_en;

   modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_en, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_en, output cfg_ready);
endinterface

// File: rtl/wavegen_sched.sv
// ---------------------------------------------------------------------------
// wavegen_sched
//   Shares one synchronous-read sine ROM across NCH PWM channels. A global
//   N-bit frame counter issues one ROM fetch per channel in cycles 1..NCH,
//   captures the samples, and reloads every channel's duty at the frame
//   boundary (end of cycle 2^N-1).
//
//   clk       in   clock
//   n_reset   in   asynchronous active-low reset
//   cfg       if   config handshake (slave modport), see wavegen_sched_if
//   rom_addr  out  ROM address, registered
//   rom_en    out  ROM read strobe, registered
//   rom_data  in   ROM sample, valid the cycle after rom_addr/rom_en
//   pwm       out  PWM outputs, registered
//   sync      out  frame-start pulse, high in cycle 0
// ---------------------------------------------------------------------------

// Per-channel state: increment, enable, phase accumulator, fetched sample
// (shadow), active duty and the PWM flop.
module wavegen_ch #(
   parameter int N  = 4,
   parameter int SN = 5,
   parameter int F  = 8
) (
   input  logic            clk,
   input  logic            n_reset,
   input  logic [N-1:0]    cnt,
   input  logic            bnd,       // last cycle of the frame
   input  logic            cap,       // this channel's ROM sample is on rom_data
   input  logic            wr,        // config transfer addressed to this channel
   input  logic            wr_en,
   input  logic [SN+F-1:0] wr_inc,
   input  logic [N-1:0]    rom_data,
   output logic [SN-1:0]   addr,
   output logic            pwm
);
   localparam int A = SN + F;

   logic [A-1:0] inc;
   logic [A-1:0] phase;
   logic         en;
   logic [N-1:0] shadow;
   logic [N-1:0] shadow_d;
   logic [N-1:0] duty;
   logic [N-1:0] duty_d;

   // Forward a sample captured on the boundary edge itself so the reload
   // never sees a stale shadow (only reachable when NCH+2 == 2^N).
   always_comb begin
      shadow_d = cap ? rom_data : shadow;
      duty_d   = en ? shadow_d : '0;
   end

   assign addr = phase[A-1:F];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         inc    <= '0;
         en     <= 1'b0;
         phase  <= '0;
         shadow <= '0;
         duty   <= '0;
         pwm    <= 1'b0;
      end else begin
         shadow <= shadow_d;
         // cfg_ready is low on the boundary cycle, so wr and bnd never coincide
         if (wr) begin
            inc <= wr_inc;
            en  <= wr_en;
            if (!wr_en) phase <= '0;
         end else if (bnd && en) begin
            phase <= phase + inc;
         end
         if (bnd) begin
            duty <= duty_d;
            pwm  <= |duty_d;
         end else if (duty != '0 && cnt == duty - N'(1)) begin
            pwm <= 1'b0;
         end
      end
   end
endmodule

module wavegen_sched #(
   parameter int NCH = 4,
   parameter int N   = 4,
   parameter int SN  = 5,
   parameter int F   = 8
) (
   input  logic             clk,
   input  logic             n_reset,
   wavegen_sched_if.slave   cfg,
   output logic [SN-1:0]    rom_addr,
   output logic             rom_en,
   input  logic [N-1:0]     rom_data,
   output logic [NCH-1:0]   pwm,
   output logic             sync
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [N-1:0] LAST = '1;

   if (NCH + 2 > (1 << N)) begin : g_bad_cfg
      $error("wavegen_sched: NCH+2 must not exceed 2**N");
   end

   logic [N-1:0]           cnt;
   logic                   last;
   logic                   xfer;
   logic                   fetch;
   logic [NCH-1:0][SN-1:0] ch_addr;
   logic [SN-1:0]          addr_sel;

   assign last          = (cnt == LAST);
   assign cfg.cfg_ready = ~last;
   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
   // Fetch for channel k is registered at the end of cycle k, so the ROM
   // sees it during cycle k+1 and returns data in cycle k+2.
   assign fetch         = (cnt < N'(NCH));

   always_comb begin
      addr_sel = '0;
      for (int k = 0; k < NCH; k++)
         if (cnt == N'(k)) addr_sel = ch_addr[k];
   end

   // Channel index outside 0..NCH-1 hits no lane, so such a transfer is a no-op.
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      wavegen_ch #(.N(N), .SN(SN), .F(F)) u_ch (
         .clk      (clk),
         .n_reset  (n_reset),
         .cnt      (cnt),
         .bnd      (last),
         .cap      (cnt == N'(k + 2)),
         .wr       (xfer && cfg.cfg_ch == CW'(k)),
         .wr_en    (cfg.cfg_en),
         .wr_inc   (cfg.cfg_inc),
         .rom_data (rom_data),
         .addr     (ch_addr[k]),
         .pwm      (pwm[k])
      );
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt      <= '0;
         rom_addr <= '0;
         rom_en   <= 1'b0;
         sync     <= 1'b0;
      end else begin
         cnt    <= cnt + N'(1);
         sync   <= last;
         rom_en <= fetch;
         if (fetch) rom_addr <= addr_sel;
      end
   end
endmodule

// File: tb/tb_wavegen_sched.sv
// ---------------------------------------------------------------------------
// tb_wavegen_sched
//   Directed scenarios followed by random config traffic. A frame-level
//   reference model predicts, for every cycle c: sync = (c==0 after a
//   boundary), rom_en = (1<=c<=NCH), rom_addr = phase[c-1] top bits, and
//   pwm[k] = (c < duty[k]). The ROM is modelled in the bench.
// ---------------------------------------------------------------------------
module tb_wavegen_sched;
   localparam int NCH  = 4;
   localparam int N    = 4;
   localparam int SN   = 5;
   localparam int F    = 8;
   localparam int A    = SN + F;
   localparam int CW   = 2;
   localparam int FR   = 1 << N;
   localparam int LAST = FR - 1;

   logic           clk = 1'b0;
   logic           n_reset;
   logic [SN-1:0]  rom_addr;
   logic           rom_en;
   logic [N-1:0]   rom_data;
   logic [NCH-1:0] pwm;
   logic           sync;

   wavegen_sched_if #(.NCH(NCH), .A(A)) cfg_if ();

   wavegen_sched #(.NCH(NCH), .N(N), .SN(SN), .F(F)) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .cfg      (cfg_if),
      .rom_addr (rom_addr),
      .rom_en   (rom_en),
      .rom_data (rom_data),
      .pwm      (pwm),
      .sync     (sync)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model
   int            c;
   logic [A-1:0]  m_inc   [NCH];
   logic [A-1:0]  m_phase [NCH];
   bit            m_en    [NCH];
   int            m_duty  [NCH];
   int            fd      [NCH];
   logic [SN-1:0] e_addr;
   bit            e_ren;
   bit            e_sync;
   bit            rom_fixed;
   logic [N-1:0]  fixv;

   function automatic logic [N-1:0] rom_fn(input logic [SN-1:0] a);
      return rom_fixed ? fixv : a[N-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, c);
      end
   endtask

   task automatic reset_model();
      c = 0;
      for (int k = 0; k < NCH; k++) begin
         m_inc[k] = '0; m_phase[k] = '0; m_en[k] = 1'b0; m_duty[k] = 0; fd[k] = 0;
      end
      e_addr = '0; e_ren = 1'b0; e_sync = 1'b0;
   endtask

   // Advance one clock: predict the edge ending cycle c, then check cycle c+1.
   task automatic tick();
      logic [N-1:0]   nr;
      logic [NCH-1:0] e_pwm;
      int             ch;
      nr     = rom_en ? rom_fn(rom_addr) : rom_data;
      e_sync = (c == LAST);
      e_ren  = (c < NCH);
      if (c < NCH) begin
         e_addr = m_phase[c][A-1:F];
         fd[c]  = int'(rom_fn(e_addr));
      end
      if (c == LAST) begin
         for (int k = 0; k < NCH; k++) begin
            m_duty[k] = m_en[k] ? fd[k] : 0;
            if (m_en[k]) m_phase[k] = m_phase[k] + m_inc[k];
         end
      end
      if (cfg_if.cfg_valid && c != LAST) begin
         ch = int'(cfg_if.cfg_ch);
         m_inc[ch] = cfg_if.cfg_inc;
         m_en[ch]  = cfg_if.cfg_en;
         if (!cfg_if.cfg_en) m_phase[ch] = '0;
      end
      c = (c + 1) % FR;
      for (int k = 0; k < NCH; k++) e_pwm[k] = (c < m_duty[k]);
      @(posedge clk);
      #1 rom_data = nr;
      @(negedge clk);
      chk("sync", 32'(sync), 32'(e_sync));
      chk("rom_en", 32'(rom_en), 32'(e_ren));
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(c != LAST));
      chk("pwm", 32'(pwm), 32'(e_pwm));
   endtask

   task automatic run_to(input int t);
      for (int i = 0; i < FR && c != t; i++) tick();
   endtask

   task automatic skip_frame();
      tick();
      run_to(0);
   endtask

   task automatic frame_hi(output int n [NCH]);
      for (int k = 0; k < NCH; k++) n[k] = 0;
      for (int i = 0; i < FR; i++) begin
         for (int k = 0; k < NCH; k++) n[k] += int'(pwm[k]);
         tick();
      end
   endtask

   task automatic cfg_wr(input int ch, input int inc, input bit en);
      cfg_if.cfg_ch    = CW'(ch);
      cfg_if.cfg_inc   = A'(inc);
      cfg_if.cfg_en    = en;
      cfg_if.cfg_valid = 1'b1;
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic do_reset();
      n_reset          = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      rom_data         = '0;
      #1;
      chk("rst_pwm", 32'(pwm), 0);
      chk("rst_rom_en", 32'(rom_en), 0);
      chk("rst_sync", 32'(sync), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      reset_model();
      #1 chk("rel_ready", 32'(cfg_if.cfg_ready), 1);
   endtask

   initial begin
      int hi [NCH];
      int exp1 [NCH];
      int exp2 [NCH];
      int expw [NCH];
      exp1 = '{1, 2, 3, 31};
      exp2 = '{2, 4, 6, 30};
      expw = '{2, 4, 6, 14};
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_inc   = '0;
      cfg_if.cfg_en    = 1'b0;
      rom_fixed        = 1'b0;
      fixv             = '0;
      reset_model();

      // reset / idle
      do_reset();
      for (int i = 0; i < FR; i++) tick();
      chk("idle_sync16", 32'(sync), 1);
      skip_frame();
      chk("idle_pwm", 32'(pwm), 0);

      // single channel
      run_to(5);
      cfg_wr(0, 'h100, 1'b1);
      run_to(0);
      tick();
      chk("sc_addr1", 32'(rom_addr), 1);
      run_to(0);
      frame_hi(hi);
      chk("sc_width1", hi[0], 1);
      frame_hi(hi);
      chk("sc_width2", hi[0], 2);

      // duty extremes
      run_to(8);
      rom_fixed = 1'b1; fixv = 4'd0;
      run_to(0);
      skip_frame();
      frame_hi(hi);
      chk("duty0_width", hi[0], 0);
      run_to(8);
      fixv = 4'd15;
      run_to(0);
      skip_frame();
      run_to(14);
      chk("duty15_c14", 32'(pwm[0]), 1);
      tick();
      chk("duty15_c15", 32'(pwm[0]), 0);
      run_to(0);
      frame_hi(hi);
      chk("duty15_width", hi[0], 15);

      // four channels from a clean start
      do_reset();
      rom_fixed = 1'b0;
      run_to(5);
      cfg_wr(0, 'h100, 1'b1);
      cfg_wr(1, 'h200, 1'b1);
      cfg_wr(2, 'h300, 1'b1);
      cfg_wr(3, 'h1F00, 1'b1);
      run_to(0);
      for (int k = 0; k < NCH; k++) begin
         tick();
         chk("q_addr_f1", 32'(rom_addr), exp1[k]);
      end
      run_to(0);
      for (int k = 0; k < NCH; k++) begin
         tick();
         chk("q_addr_f2", 32'(rom_addr), exp2[k]);
      end
      run_to(0);
      frame_hi(hi);
      for (int k = 0; k < NCH; k++) chk("q_width", hi[k], expw[k]);

      // config timing around the boundary
      run_to(LAST);
      cfg_if.cfg_ch = 2'd2; cfg_if.cfg_inc = 13'h0500; cfg_if.cfg_en = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      chk("ready_c15", 32'(cfg_if.cfg_ready), 0);
      tick();
      chk("ready_c0", 32'(cfg_if.cfg_ready), 1);
      tick();
      cfg_if.cfg_valid = 1'b0;
      skip_frame();

      // disable mid-frame, then re-enable
      run_to(8);
      rom_fixed = 1'b1; fixv = 4'd10;
      run_to(0);
      skip_frame();
      run_to(3);
      chk("dis_pre", 32'(pwm[1]), 1);
      cfg_wr(1, 'h0A00, 1'b0);
      run_to(9);
      chk("dis_c9", 32'(pwm[1]), 1);
      tick();
      chk("dis_c10", 32'(pwm[1]), 0);
      run_to(0);
      frame_hi(hi);
      chk("dis_width", hi[1], 0);
      chk("dis_other", hi[0], 10);
      run_to(6);
      rom_fixed = 1'b0;
      cfg_wr(1, 'h0A00, 1'b1);
      run_to(0);
      run_to(2);
      chk("reen_addr", 32'(rom_addr), 10);

      // async reset mid-frame with pwm high
      run_to(0);
      run_to(5);
      chk("ar_pre", 32'(pwm[1]), 1);
      do_reset();
      skip_frame();
      skip_frame();

      // random config traffic and ROM contents
      for (int fr = 0; fr < 20; fr++) begin
         for (int i = 0; i < FR; i++) begin
            if (c == 10) begin
               rom_fixed = ($urandom_range(0, 1) == 1);
               fixv      = N'($urandom);
            end
            cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_if.cfg_inc   = A'($urandom);
            cfg_if.cfg_en    = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      cfg_if.cfg_valid = 1'b0;
      skip_frame();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
